uart_rx: RTL and testbench

UART receiver, the far end of the team's UART transmitter.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional odd-parity bit, one stop bit (1).
- Samples the asynchronous rx_pin on an oversampled tick from the shared baud generator.
- Delivers each byte with a one-clk valid pulse and per-frame error flags to the host/FIFO side.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 35 +++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver (and the transmitter side).
//   - UART_DATA_BITS / UART_OVERSAMPLE : default frame width and oversampling
//   - rx_state_t                        : receiver FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high reset (flops load RESET_VAL)
//   i_async  in  asynchronous input
//   o_sync   out synchronized copy of i_async (two clk latency)
// -----------------------------------------------------------------------------
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage metastability filter; reset value matches the line's idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit (0), DATA_BITS data bits LSB first, optional odd
// parity bit, one stop bit (1). The line is sampled on the oversampled tick.
// Ports:
//   clk            in  system clock
//   reset          in  asynchronous, active-high reset
//   sample_tick    in  one-clk pulse at OVERSAMPLE x baud
//   rx_pin         in  serial line (asynchronous, idle high)
//   parity_enable  in  frame carries an odd-parity bit after the data
//   rx_data        out received word, held until the next frame completes
//   rx_valid       out one-clk pulse: rx_data and error flags valid
//   parity_error   out parity mismatch on last frame
//   framing_error  out stop bit sampled 0 on last frame
//   rx_busy        out high from start-bit detection until the frame ends
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_pin,
  input  logic                 parity_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en;
  logic                 r_parity_ok;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx_pin),
    .o_sync  (w_rx_s)
  );

  // Receiver FSM with registered outputs; only advances on sample_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_par_en      <= 1'b0;
      r_parity_ok   <= 1'b1;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (sample_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state    <= START;
              r_tick_cnt <= '0;
              rx_busy    <= 1'b1;
            end
          end

          START: begin
            if (r_tick_cnt == TICK_MID) begin
              if (w_rx_s) begin
                // Line back high before mid start bit: treat as a glitch.
                r_state <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                r_tick_cnt  <= '0;
                r_bit_idx   <= '0;
                // Frame format is frozen here so mid-frame changes are ignored.
                r_par_en    <= parity_enable;
                r_parity_ok <= 1'b1;
                r_state     <= DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end

          DATA: begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              // Shift in at the MSB so the first (LSB) bit ends at bit 0.
              r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_bit_idx == BIT_LAST) begin
                r_state <= r_par_en ? PARITY : STOP;
              end else begin
                r_bit_idx <= r_bit_idx + BIT_ONE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end

          PARITY: begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt  <= '0;
              // Odd parity: data plus parity bit must hold an odd count of ones.
              r_parity_ok <= ^{r_shift, w_rx_s};
              r_state     <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end

          STOP: begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt    <= '0;
              rx_data       <= r_shift;
              parity_error  <= r_par_en & ~r_parity_ok;
              framing_error <= ~w_rx_s;
              rx_valid      <= 1'b1;
              if (w_rx_s) begin
                r_state <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                // Line held low (break): wait for idle before re-arming.
                r_state <= BREAK_WAIT;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_ONE;
            end
          end

          BREAK_WAIT: begin
            if (w_rx_s) begin
              r_state <= IDLE;
              rx_busy <= 1'b0;
            end
          end

          default: begin
            r_state <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx (DATA_BITS=8, OVERSAMPLE=16). Stimulus pushes the
// expected frame result into a queue; a monitor pops and compares on rx_valid.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx_pin = 1'b1;
  logic       parity_enable = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       framing_error;
  logic       rx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t   exp_q[$];
  longint valid_tick[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_valid = 0;
  longint tick_cnt = 0;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .rx_pin        (rx_pin),
    .parity_enable (parity_enable),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  // sample_tick: one clk high out of every four
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (sample_tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      exp_t e;
      n_valid++;
      valid_tick.push_back(tick_cnt);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got rx_valid with data 0x%0h, expected none (t=%0t)", rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("parity_error", 32'(parity_error), 32'(e.perr));
        check("framing_error", 32'(framing_error), 32'(e.ferr));
        // busy drops with rx_valid unless the stop bit was low (break wait)
        check("busy_at_valid", 32'(rx_busy), 32'(e.ferr));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (sample_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pbit, input logic stop);
    rx_pin = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      wait_ticks(16);
    end
    if (use_par) begin
      rx_pin = pbit;
      wait_ticks(16);
    end
    rx_pin = stop;
    wait_ticks(16);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_parity_error"}, 32'(parity_error), 32'd0);
    check({tag, "_framing_error"}, 32'(framing_error), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     nv;
    int     idx;
    longint d1;
    longint d2;

    // Reset state
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_ticks(4);

    // 1: plain 8N1 frame 0xA5
    parity_enable = 1'b0;
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_drain("t1_drain");

    // 2: odd parity; data+parity must hold an odd number of ones
    parity_enable = 1'b1;
    push_exp(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);  // 1 one + p0 -> odd, ok
    push_exp(8'h03, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);  // 2 ones + p1 -> odd, ok
    push_exp(8'h03, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);  // 2 ones + p0 -> even, error
    push_exp(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);  // 3 ones + p1 -> even, error
    wait_drain("t2_drain");
    parity_enable = 1'b0;
    wait_ticks(8);

    // 3: start glitch of 4 ticks, then a real frame
    nv = n_valid;
    rx_pin = 1'b0;
    wait_ticks(4);
    check("t3_busy_during_glitch", 32'(rx_busy), 32'd1);
    rx_pin = 1'b1;
    wait_ticks(16);
    check("t3_busy_after_glitch", 32'(rx_busy), 32'd0);
    check("t3_no_valid_on_glitch", 32'(n_valid), 32'(nv));
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_drain("t3_drain");

    // 4: stop bit 0 followed by line held low for 20 bit times
    push_exp(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_drain("t4_drain");
    nv = n_valid;
    wait_ticks(320);
    check("t4_busy_while_low", 32'(rx_busy), 32'd1);
    check("t4_no_second_valid", 32'(n_valid), 32'(nv));
    rx_pin = 1'b1;
    wait_ticks(3);
    check("t4_busy_after_high", 32'(rx_busy), 32'd0);
    wait_ticks(8);

    // 5: reset in the middle of data bit 4 of 0xFF
    nv = n_valid;
    rx_pin = 1'b0;
    wait_ticks(16);
    rx_pin = 1'b1;
    wait_ticks(64 + 8);
    check("t5_busy_before_reset", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_async_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(20);
    check("t5_no_valid_after_reset", 32'(n_valid), 32'(nv));
    push_exp(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_drain("t5_drain");

    // 6: back-to-back frames, no idle gap
    idx = valid_tick.size();
    push_exp(8'h00, 1'b0, 1'b0);
    push_exp(8'hFF, 1'b0, 1'b0);
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_drain("t6_drain");
    check("t6_valid_count", 32'(valid_tick.size() - idx), 32'd3);
    if (valid_tick.size() >= idx + 3) begin
      d1 = valid_tick[idx + 1] - valid_tick[idx];
      d2 = valid_tick[idx + 2] - valid_tick[idx + 1];
      check("t6_spacing_1", 32'(d1), 32'd160);
      check("t6_spacing_2", 32'(d2), 32'd160);
    end

    wait_ticks(16);
    check("total_valid_count", 32'(n_valid), 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
